// File: rtl/prefetch_queue_if.sv
// Signal bundle between the prefetch queue, the RAM read port and the decoder.
// The master modport is the prefetch queue itself; slave is its environment.
interface prefetch_queue_if;
  logic        bus_busy;
  logic        flush;
  logic [19:0] flush_addr;

  logic        pq_rd_en;
  logic        pq_rd_we;
  logic        pq_rd_de;
  logic [19:0] pq_rd_addr;
  logic [31:0] pq_rd_data;

  logic        q_pop;
  logic [2:0]  q_pop_num;
  logic [31:0] q_data;
  logic [3:0]  q_cnt;
  logic [19:0] q_addr;

  modport master (
    input  bus_busy, flush, flush_addr, pq_rd_data, q_pop, q_pop_num,
    output pq_rd_en, pq_rd_we, pq_rd_de, pq_rd_addr, q_data, q_cnt, q_addr
  );

  modport slave (
    output bus_busy, flush, flush_addr, pq_rd_data, q_pop, q_pop_num,
    input  pq_rd_en, pq_rd_we, pq_rd_de, pq_rd_addr, q_data, q_cnt, q_addr
  );
endinterface

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches dword-aligned words from RAM into a byte
// ring buffer and exposes a 4-byte peek window to the decoder.
module prefetch_queue #(
  parameter int unsigned QUEUE_DEPTH = 6,
  parameter logic [19:0] RESET_ADDR  = 20'hFFFF0
) (
  input logic              clk,
  input logic              rst_n,
  prefetch_queue_if.master pq
);

  localparam int unsigned IW    = $clog2(QUEUE_DEPTH);
  localparam logic [5:0]  DEPTH = 6'(QUEUE_DEPTH);

  logic [7:0]    mem [QUEUE_DEPTH];
  logic [IW-1:0] head;
  logic [3:0]    cnt;
  logic [19:0]   fetch_ptr;
  logic [19:0]   q_addr_r;

  logic [2:0]    n_fetch;
  logic [5:0]    space;
  logic          rd_en;
  logic          pop_ok;
  logic [2:0]    pop_n;
  logic [31:0]   rd_shifted;
  logic [31:0]   q_data_w;

  // Operands never exceed 3*DEPTH-1, so two conditional subtracts give the modulo.
  function automatic logic [IW-1:0] wrap(input logic [5:0] v);
    logic [5:0] r;
    r = v;
    if (r >= DEPTH) r = r - DEPTH;
    if (r >= DEPTH) r = r - DEPTH;
    return r[IW-1:0];
  endfunction

  always_comb begin
    n_fetch    = 3'd4 - {1'b0, fetch_ptr[1:0]};
    space      = DEPTH - 6'(cnt);
    rd_en      = rst_n & ~pq.flush & ~pq.bus_busy & (space >= 6'(n_fetch));
    pop_ok     = pq.q_pop && (pq.q_pop_num != 3'd0) && (pq.q_pop_num <= 3'd4)
                 && (4'(pq.q_pop_num) <= cnt);
    pop_n      = pop_ok ? pq.q_pop_num : '0;
    // Align the first wanted byte of an unaligned fetch to lane 0.
    rd_shifted = pq.pq_rd_data >> {fetch_ptr[1:0], 3'b000};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head      <= '0;
      cnt       <= '0;
      fetch_ptr <= RESET_ADDR;
      q_addr_r  <= RESET_ADDR;
    end else if (pq.flush) begin
      head      <= '0;
      cnt       <= '0;
      fetch_ptr <= pq.flush_addr;
      q_addr_r  <= pq.flush_addr;
    end else begin
      head     <= wrap(6'(head) + 6'(pop_n));
      cnt      <= cnt - 4'(pop_n) + (rd_en ? 4'(n_fetch) : 4'd0);
      q_addr_r <= q_addr_r + 20'(pop_n);
      if (rd_en) fetch_ptr <= {fetch_ptr[19:2], 2'b00} + 20'd4;
    end
  end

  // Tail slots are addressed from the pre-pop count, so popped slots are never
  // reused in the same cycle and pushed bytes land behind the survivors.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < 4; k++) begin
      if (rd_en && (3'(k) < n_fetch))
        mem[wrap(6'(head) + 6'(cnt) + 6'(k))] <= rd_shifted[8*k +: 8];
    end
  end

  always_comb begin
    q_data_w = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (4'(i) < cnt)
        q_data_w[8*i +: 8] = mem[wrap(6'(head) + 6'(i))];
    end
  end

  assign pq.pq_rd_en   = rd_en;
  assign pq.pq_rd_we   = 1'b0;
  assign pq.pq_rd_de   = 1'b1;
  assign pq.pq_rd_addr = {fetch_ptr[19:2], 2'b00};
  assign pq.q_data     = q_data_w;
  assign pq.q_cnt      = cnt;
  assign pq.q_addr     = q_addr_r;

endmodule

// File: tb/tb_prefetch_queue.sv
// Scoreboard bench for prefetch_queue: a byte-queue reference model predicts
// each cycle's fetch request and post-edge queue view; a monitor compares.
module tb_prefetch_queue;
  localparam int unsigned DEPTH    = 6;
  localparam logic [19:0] RST_ADDR = 20'hFFFF0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prefetch_queue_if pif();

  prefetch_queue #(.QUEUE_DEPTH(DEPTH), .RESET_ADDR(RST_ADDR)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .pq   (pif.master)
  );

  logic [7:0] ram_init [logic [19:0]];

  function automatic logic [7:0] ram_byte(input logic [19:0] a);
    if (ram_init.exists(a)) return ram_init[a];
    return 8'(a ^ (a >> 7) ^ (a >> 13)) + 8'h5A;
  endfunction

  function automatic logic [31:0] ram_word(input logic [19:0] a);
    return {ram_byte(a + 20'd3), ram_byte(a + 20'd2), ram_byte(a + 20'd1), ram_byte(a)};
  endfunction

  assign pif.pq_rd_data = ram_word(pif.pq_rd_addr);

  typedef struct {
    logic        chk_addr;
    logic        rd_en;
    logic [19:0] rd_addr;
    logic [3:0]  cnt;
    logic [31:0] data;
    logic [19:0] qaddr;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mq[$];
  logic [19:0] m_fp = RST_ADDR;
  logic [19:0] m_qa = RST_ADDR;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
    end
  endtask

  // One clock cycle: drive inputs, advance the reference model, queue the expectation.
  task automatic step(input logic r, input logic busy, input logic fl,
                      input logic [19:0] fa, input logic pop, input logic [2:0] pn);
    exp_t        e;
    int          nf;
    logic [19:0] base;
    @(negedge clk);
    rst_n          = r;
    pif.bus_busy   = busy;
    pif.flush      = fl;
    pif.flush_addr = fa;
    pif.q_pop      = pop;
    pif.q_pop_num  = pn;

    nf        = 4 - int'(m_fp[1:0]);
    base      = m_fp & 20'hFFFFC;
    e.chk_addr = r;
    e.rd_en   = r && !fl && !busy && (int'(DEPTH) - mq.size() >= nf);
    e.rd_addr = base;

    if (!r) begin
      mq.delete();
      m_fp = RST_ADDR;
      m_qa = RST_ADDR;
    end else if (fl) begin
      mq.delete();
      m_fp = fa;
      m_qa = fa;
    end else begin
      if (pop && pn >= 3'd1 && pn <= 3'd4 && int'(pn) <= mq.size()) begin
        repeat (int'(pn)) void'(mq.pop_front());
        m_qa = m_qa + 20'(pn);
      end
      if (e.rd_en) begin
        for (int a = int'(m_fp[1:0]); a < 4; a++) mq.push_back(ram_byte(base + 20'(a)));
        m_fp = base + 20'd4;
      end
    end

    e.cnt  = 4'(mq.size());
    e.data = '0;
    for (int i = 0; i < 4; i++) if (i < mq.size()) e.data[8*i +: 8] = mq[i];
    e.qaddr = m_qa;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    logic        s_en;
    logic [19:0] s_addr;
    exp_t        e;
    forever begin
      @(negedge clk);
      #4;
      s_en   = pif.pq_rd_en;
      s_addr = pif.pq_rd_addr;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pq_rd_en", 32'(s_en), 32'(e.rd_en));
        if (e.chk_addr) chk("pq_rd_addr", 32'(s_addr), 32'(e.rd_addr));
        chk("q_cnt", 32'(pif.q_cnt), 32'(e.cnt));
        chk("q_data", pif.q_data, e.data);
        chk("q_addr", 32'(pif.q_addr), 32'(e.qaddr));
        chk("rd_size_sel", {30'd0, pif.pq_rd_we, pif.pq_rd_de}, 32'd1);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic        r, busy, fl, pop;
    logic [19:0] fa;
    logic [2:0]  pn;

    ram_init[20'hFFFF0] = 8'h11; ram_init[20'hFFFF1] = 8'h22;
    ram_init[20'hFFFF2] = 8'h33; ram_init[20'hFFFF3] = 8'h44;
    ram_init[20'h00100] = 8'hA0; ram_init[20'h00101] = 8'hA1;
    ram_init[20'h00102] = 8'hA2; ram_init[20'h00103] = 8'hA3;
    pif.bus_busy = 1'b0; pif.flush = 1'b0; pif.flush_addr = '0;
    pif.q_pop = 1'b0; pif.q_pop_num = '0;

    repeat (2) step(1'b0, 1'b0, 1'b0, '0, 1'b0, 3'd0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 3'd0);          // fetch FFFF0 -> 44332211
    repeat (2) step(1'b1, 1'b0, 1'b0, '0, 1'b0, 3'd0); // space 2, no fetch
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, 3'd2);          // pop 2
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 3'd0);          // fetch FFFF4 -> cnt 6
    step(1'b1, 1'b0, 1'b1, 20'h00103, 1'b0, 3'd0);   // flush
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 3'd0);          // 1-byte fetch A3
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 3'd0);          // fetch 00104
    step(1'b1, 1'b0, 1'b1, 20'hFFFFC, 1'b0, 3'd0);   // flush near top
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 3'd0);          // fetch FFFFC, wrap
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, 3'd4);          // pop 4, addr 00000 shown
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 3'd0);          // fetch 00000
    step(1'b1, 1'b1, 1'b0, '0, 1'b1, 3'd4);          // drain under busy
    repeat (5) step(1'b1, 1'b1, 1'b0, '0, 1'b0, 3'd0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 3'd0);          // fetch resumes
    step(1'b1, 1'b0, 1'b1, 20'h2A5A6, 1'b1, 3'd2);   // flush beats pop
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 3'd0);          // 2-byte fetch
    step(1'b1, 1'b1, 1'b0, '0, 1'b1, 3'd3);          // pop 3 > cnt 2 ignored
    step(1'b1, 1'b1, 1'b0, '0, 1'b1, 3'd0);          // pop 0 ignored
    step(1'b1, 1'b1, 1'b0, '0, 1'b1, 3'd5);          // pop 5 ignored
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 3'd0);          // reset while fetch would fire
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 3'd0);

    for (int n = 0; n < 3000; n++) begin
      r    = ($urandom_range(0, 99) != 0);
      busy = ($urandom_range(0, 3) == 0);
      fl   = ($urandom_range(0, 19) == 0);
      fa   = ($urandom_range(0, 3) == 0) ? 20'hFFFF0 + 20'($urandom_range(0, 15))
                                         : 20'($urandom);
      pop  = 1'($urandom_range(0, 1));
      pn   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                         : 3'($urandom_range(1, 4));
      step(r, busy, fl, fa, pop, pn);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prefetch_queue.md
Name: prefetch_queue

Overview:
- Instruction prefetch queue of the bus interface unit; sits directly upstream of the decoder and is a client of the RAM read port (20-bit byte address; en/we/de size select; 32-bit combinational read data).
- Fetches dword-aligned 32-bit words from RAM into a byte FIFO whenever the bus is free and space allows.
- Exposes a 4-byte peek window to the decoder, which pops 1–4 bytes per cycle.
- A flush (jump/branch/interrupt) discards queued bytes and restarts fetch at a new physical address.

Parameters:
- QUEUE_DEPTH, 6, queue capacity in bytes; legal 4..15.
- RESET_ADDR, 20'hFFFF0, fetch pointer after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active low.
- bus_busy  input  1  execution unit owns the RAM read port this cycle; no fetch.
- flush  input  1  discard queue and restart fetch at flush_addr.
- flush_addr  input  20  new physical fetch address.
- pq_rd_en  output  1  RAM read enable.
- pq_rd_we  output  1  RAM word-size select; constant 0.
- pq_rd_de  output  1  RAM dword-size select; constant 1.
- pq_rd_addr  output  20  RAM read address; always {fetch_ptr[19:2], 2'b00}.
- pq_rd_data  input  32  RAM read data, valid in the same cycle as pq_rd_en; byte n is at address base+n.
- q_pop  input  1  decoder consumes bytes this cycle.
- q_pop_num  input  3  bytes consumed, 1..4.
- q_data  output  32  peek window; [7:0] is the oldest byte, then ascending.
- q_cnt  output  4  bytes currently queued.
- q_addr  output  20  physical address of q_data[7:0].

Behaviour:
- State: byte array [QUEUE_DEPTH], head index, q_cnt, fetch_ptr[19:0], q_addr[19:0].
- Reset (rst_n=0 at an edge), regardless of any other input:
  - q_cnt=0, head=0.
  - fetch_ptr=RESET_ADDR, q_addr=RESET_ADDR.
  - Takes effect mid-fetch; the in-flight read is dropped.
- Fetch size: n_fetch = 4 - fetch_ptr[1:0]. An unaligned fetch uses only bytes fetch_ptr[1:0]..3 of pq_rd_data.
- pq_rd_en (combinational) = rst_n & ~flush & ~bus_busy & (QUEUE_DEPTH - q_cnt >= n_fetch).
  - Free space is computed from q_cnt before any same-cycle pop; a pop does not enable a same-cycle fetch.
- Push: on an edge with pq_rd_en=1:
  - Append the n_fetch bytes in ascending address order at the tail.
  - fetch_ptr <= {fetch_ptr[19:2], 2'b00} + 4, wrapping modulo 2^20 (20'hFFFFC -> 20'h00000).
- Pop: valid when q_pop=1 and 1 <= q_pop_num <= q_cnt.
  - head advances by q_pop_num, modulo QUEUE_DEPTH.
  - q_addr <= q_addr + q_pop_num, modulo 2^20.
- Illegal pop (q_pop_num=0, >4, or > q_cnt): ignored, no state change.
- Push and legal pop in the same cycle: q_cnt <= q_cnt + n_fetch - q_pop_num.
  - The pushed bytes land behind the remaining bytes.
- Flush (rst_n=1, flush=1) has priority over push and pop:
  - q_cnt <= 0, head <= 0.
  - fetch_ptr <= flush_addr, q_addr <= flush_addr.
  - pq_rd_en=0 in the flush cycle; the earliest fetch is the next cycle.
- q_data: byte i (i=0..3) = queue[head+i mod QUEUE_DEPTH] if i < q_cnt, else 8'h00.
  - Registered state only; no bypass of same-cycle pq_rd_data.
- Latency: a byte fetched at edge t is visible in q_data after edge t.
- bus_busy stalls fetch indefinitely; pops continue.

Test Plan:
- Reset release, bus free, RAM[FFFF0..FFFF3]=11,22,33,44:
  - Cycle 1: pq_rd_en=1, pq_rd_addr=FFFF0.
  - Next: q_cnt=4, q_data=32'h44332211, q_addr=FFFF0.
  - No further fetch (space 2 < 4) until a pop.
- q_cnt=4, pop 2:
  - q_cnt=2, q_data=32'h00004433, q_addr=FFFF2.
  - Next cycle: fetch FFFF4 -> q_cnt=6.
- Flush to 20'h00103 with RAM[100..103]=A0,A1,A2,A3:
  - Flush cycle: pq_rd_en=0.
  - Next cycle: pq_rd_addr=00100; 1 byte pushed; q_data=32'h000000A3, q_cnt=1, q_addr=00103.
  - Following fetch address: 00104.
- Flush to FFFFC:
  - Fetch returns 4 bytes; fetch_ptr wraps; next pq_rd_addr=00000.
- bus_busy=1 for 5 cycles with the queue empty:
  - pq_rd_en=0 throughout, q_cnt stays 0.
  - Fetch begins on the first cycle bus_busy=0.
- Boundary events:
  - flush and pop(2) together with q_cnt=4 -> q_cnt=0, q_addr=flush_addr.
  - pop_num=3 with q_cnt=2 -> no change.
  - rst_n=0 while pq_rd_en=1 -> q_cnt=0, fetch_ptr=FFFF0.
